// File: rtl/alu_pkg.sv
// Shared types for the ALU result FIFO: default operand width, result layout
// and occupancy states.
package alu_pkg;

  localparam int NB_BITS_DEF = 32;

  typedef struct packed {
    logic                   carry;
    logic [NB_BITS_DEF-1:0] data;
  } result_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/sum_fifo_ram.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// Contents are not reset.
module sum_fifo_ram #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO for registered ALU sums with carry; overflowing writes are dropped
// and flagged. Define ALU_CARRY_COUNT_EN to add a saturating carry counter output.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int NB_BITS = NB_BITS_DEF,
  parameter int DEPTH   = 8
) (
  input  logic                       clock_i,
  input  logic                       rst_i,
  input  logic [NB_BITS:0]           sum_i,
  input  logic                       sum_valid_i,
  input  logic                       ready_i,
  output logic [NB_BITS-1:0]         data_o,
  output logic                       carry_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_o
`ifdef ALU_CARRY_COUNT_EN
  ,
  output logic [15:0]                carry_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic               carry;
    logic [NB_BITS-1:0] data;
  } entry_t;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  occ_state_e    state;
  entry_t        head;
  logic          rd, wr;

  // Flags come straight from the state register, so they are glitch-free.
  assign valid_o = (state != EMPTY);
  assign full_o  = (state == FULL);
  assign rd      = valid_o & ready_i;
  assign wr      = sum_valid_i & (~full_o | rd);
  assign count_o = count;

  sum_fifo_ram #(.W(NB_BITS + 1), .DEPTH(DEPTH)) u_ram (
    .clk   (clock_i),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata (sum_i),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign data_o  = valid_o ? head.data  : '0;
  assign carry_o = valid_o ? head.carry : 1'b0;

  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= EMPTY;
      drop_o <= 1'b0;
    end else begin
      drop_o <= sum_valid_i & full_o & ~rd;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      // Simultaneous read and write leaves count and state alone.
      case (state)
        EMPTY: if (wr) begin
          state <= PARTIAL;
          count <= CW'(1);
        end
        PARTIAL: begin
          if (wr && !rd) begin
            count <= count + CW'(1);
            if (count == CW'(DEPTH - 1)) state <= FULL;
          end else if (rd && !wr) begin
            count <= count - CW'(1);
            if (count == CW'(1)) state <= EMPTY;
          end
        end
        FULL: if (rd && !wr) begin
          state <= PARTIAL;
          count <= count - CW'(1);
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef ALU_CARRY_COUNT_EN
  always_ff @(posedge clock_i) begin
    if (rst_i)
      carry_cnt_o <= '0;
    else if (wr && sum_i[NB_BITS] && carry_cnt_o != 16'hFFFF)
      carry_cnt_o <= carry_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo with a queue model for the wrap test.
module tb_alu_result_fifo;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [32:0] sum;
  logic        sum_valid;
  logic        ready;
  logic [31:0] data;
  logic        carry;
  logic        valid;
  logic        full;
  logic [3:0]  count;
  logic        drop;
`ifdef ALU_CARRY_COUNT_EN
  logic [15:0] carry_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  alu_result_fifo #(.NB_BITS(32), .DEPTH(8)) dut (
    .clock_i     (clk),
    .rst_i       (rst),
    .sum_i       (sum),
    .sum_valid_i (sum_valid),
    .ready_i     (ready),
    .data_o      (data),
    .carry_o     (carry),
    .valid_o     (valid),
    .full_o      (full),
    .count_o     (count),
    .drop_o      (drop)
`ifdef ALU_CARRY_COUNT_EN
    ,
    .carry_cnt_o (carry_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    result_t r;
    int      drops;
    int      widx;
    int      cyc;
    logic    rd_now;
    logic    [32:0] q[$];

    rst = 1'b1; sum = '0; sum_valid = 1'b0; ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_full",  64'(full),  64'(0));
    chk("rst_drop",  64'(drop),  64'(0));
    chk("rst_data",  64'(data),  64'(0));

    // Single write, latency 1
    sum = 33'd15; sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
    chk("w1_valid", 64'(valid), 64'(1));
    chk("w1_data",  64'(data),  64'(15));
    chk("w1_carry", 64'(carry), 64'(0));
    chk("w1_count", 64'(count), 64'(1));
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("w1_drain", 64'(valid), 64'(0));

    // Carry-only result
    r.carry = 1'b1; r.data = 32'h0;
    sum = r; sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
    chk("cy_data",  64'(data),  64'(0));
    chk("cy_carry", 64'(carry), 64'(1));
`ifdef ALU_CARRY_COUNT_EN
    chk("cy_cnt", 64'(carry_cnt), 64'(1));
`endif
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("cy_drain", 64'(valid), 64'(0));

    // Overfill with 9 writes: one drop
    drops = 0;
    for (int i = 1; i <= 9; i++) begin
      sum = 33'(i); sum_valid = 1'b1;
      step();
      if (drop) drops++;
    end
    sum_valid = 1'b0;
    chk("of_full",  64'(full),  64'(1));
    chk("of_count", 64'(count), 64'(8));
    step();
    if (drop) drops++;
    chk("of_drops", 64'(drops), 64'(1));
    ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("of_rd", 64'(data), 64'(i));
      step();
    end
    ready = 1'b0;
    chk("of_empty", 64'(valid), 64'(0));

    // Simultaneous read and write while full
    for (int i = 1; i <= 8; i++) begin
      sum = 33'(i); sum_valid = 1'b1;
      step();
    end
    sum = 33'd100; ready = 1'b1;
    step();
    sum_valid = 1'b0; ready = 1'b0;
    chk("rw_count", 64'(count), 64'(8));
    chk("rw_full",  64'(full),  64'(1));
    chk("rw_drop",  64'(drop),  64'(0));
    ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      chk("rw_rd", 64'(data), (i == 9) ? 64'(100) : 64'(i));
      step();
    end
    ready = 1'b0;
    chk("rw_empty", 64'(valid), 64'(0));

    // Reset mid-operation, with a write presented during reset
    for (int i = 0; i < 3; i++) begin
      sum = 33'(7 + i); sum_valid = 1'b1;
      step();
    end
    chk("mr_count3", 64'(count), 64'(3));
    rst = 1'b1; sum = 33'd55;
    step();
    rst = 1'b0; sum_valid = 1'b0;
    chk("mr_valid", 64'(valid), 64'(0));
    chk("mr_count", 64'(count), 64'(0));
    chk("mr_data",  64'(data),  64'(0));
    chk("mr_full",  64'(full),  64'(0));
    chk("mr_fsm",   64'(dut.state), 64'(EMPTY));
`ifdef ALU_CARRY_COUNT_EN
    chk("mr_cnt", 64'(carry_cnt), 64'(0));
`endif

    // 20 values with ready toggling; source stalls rather than overflow
    widx = 0;
    cyc  = 0;
    while ((widx < 20 || q.size() > 0) && cyc < 200) begin
      ready = cyc[0];
      chk("wr_valid", 64'(valid), 64'(q.size() > 0));
      chk("wr_count", 64'(count), 64'(q.size()));
      if (q.size() > 0) chk("wr_data", 64'(data), 64'(q[0]));
      rd_now = (q.size() > 0) && ready;
      sum_valid = (widx < 20) && (q.size() < 8 || rd_now);
      sum = 33'(1000 + widx);
      step();
      if (rd_now) void'(q.pop_front());
      if (sum_valid) begin
        q.push_back(33'(1000 + widx));
        widx++;
      end
      cyc++;
    end
    sum_valid = 1'b0; ready = 1'b0;
    chk("wr_done", 64'(widx), 64'(20));
    chk("wr_left", 64'(q.size()), 64'(0));
    chk("wr_empty", 64'(valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
